// File: rtl/pq_pkg.sv
// Shared definitions for the priority-queue front end: op codes, FSM states, capacity helper.
package pq_pkg;

    localparam logic [1:0] PQ_OP_IDLE = 2'b00;
    localparam logic [1:0] PQ_OP_ENQ  = 2'b01;
    localparam logic [1:0] PQ_OP_DEQ  = 2'b10;

    localparam int unsigned STAT_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ENQ_WAIT = 2'd1,
        ST_DEQ_WAIT = 2'd2
    } pq_state_t;

    function automatic int unsigned cap(input int unsigned l);
        return (32'd1 << l) - 32'd1;
    endfunction

endpackage

// File: rtl/pq_rr_arb.sv
// Round-robin arbiter: grants the first requester at or after i_ptr, cyclically.
module pq_rr_arb #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [PW-1:0]   i_ptr,
    output logic [NREQ-1:0] o_grant_c,
    output logic [PW-1:0]   o_idx_c
);

    localparam int unsigned SW = PW + 1;

    logic [SW-1:0] w_sum;
    logic          w_found;

    always_comb begin
        o_grant_c = '0;
        o_idx_c   = '0;
        w_found   = 1'b0;
        w_sum     = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            // ptr and k are both below NREQ, so one subtraction wraps the sum
            w_sum = SW'(i_ptr) + SW'(k);
            if (w_sum >= SW'(NREQ)) begin
                w_sum = w_sum - SW'(NREQ);
            end
            if (!w_found && i_req[w_sum[PW-1:0]]) begin
                w_found                    = 1'b1;
                o_grant_c[w_sum[PW-1:0]]   = 1'b1;
                o_idx_c                    = w_sum[PW-1:0];
            end
        end
    end

endmodule

// File: rtl/pq_sched.sv
// Front-end scheduler for the tree priority queue: round-robin enqueue, spaced issue, output drain.
// Optional statistics counters are enabled with PQ_SCHED_STATS_EN.
module pq_sched
    import pq_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned W    = 32,
    parameter int unsigned L    = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NREQ-1:0]     in_valid,
    input  logic [NREQ*W-1:0]   in_data,
    output logic [NREQ-1:0]     in_ready,
    output logic                out_valid,
    output logic [W-1:0]        out_data,
    input  logic                out_ready,
    output logic                pq_enq_valid,
    output logic [W-1:0]        pq_enq_value,
    input  logic                pq_enq_ready,
    output logic                pq_deq_req,
    input  logic [W-1:0]        pq_deq_value,
    input  logic                pq_deq_valid,
    output logic [L-1:0]        count,
    output logic                err
`ifdef PQ_SCHED_STATS_EN
    ,
    output logic [STAT_W-1:0]   stat_enq,
    output logic [STAT_W-1:0]   stat_deq,
    output logic [STAT_W-1:0]   stat_full_stall
`endif
);

    localparam int unsigned CAP = cap(L);
    localparam int unsigned PW  = (NREQ > 1) ? $clog2(NREQ) : 1;

    pq_state_t      r_state;
    pq_state_t      w_state_nxt;
    logic [1:0]     w_op;
    logic [L-1:0]   r_count;
    logic [PW-1:0]  r_rr_ptr;
    logic [PW-1:0]  w_ptr_nxt;
    logic           r_out_valid;
    logic [W-1:0]   r_out_data;
    logic           r_err;
    logic [NREQ-1:0] w_grant;
    logic [PW-1:0]  w_idx;
    logic           w_full;

    pq_rr_arb #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_arb (
        .i_req     (in_valid),
        .i_ptr     (r_rr_ptr),
        .o_grant_c (w_grant),
        .o_idx_c   (w_idx)
    );

    assign w_full    = (r_count == L'(CAP));
    assign w_ptr_nxt = (w_idx == PW'(NREQ - 1)) ? '0 : w_idx + PW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Op selection: draining the output register beats new enqueues.
    always_comb begin
        w_state_nxt  = r_state;
        w_op         = PQ_OP_IDLE;
        in_ready     = '0;
        pq_enq_valid = 1'b0;
        pq_enq_value = '0;
        pq_deq_req   = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (rst_n && !r_out_valid && (r_count != '0)) begin
                    w_op        = PQ_OP_DEQ;
                    w_state_nxt = ST_DEQ_WAIT;
                end else if (rst_n && (|in_valid) && !w_full && pq_enq_ready) begin
                    w_op        = PQ_OP_ENQ;
                    w_state_nxt = ST_ENQ_WAIT;
                end
            end
            ST_ENQ_WAIT: w_state_nxt = ST_IDLE;
            ST_DEQ_WAIT: w_state_nxt = ST_IDLE;
            default:     w_state_nxt = ST_IDLE;
        endcase
        if (w_op == PQ_OP_ENQ) begin
            in_ready     = w_grant;
            pq_enq_valid = 1'b1;
            pq_enq_value = in_data[int'(w_idx)*W +: W];
        end
        pq_deq_req = (w_op == PQ_OP_DEQ);
    end

    // Occupancy, arbitration pointer, output register and sticky error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count     <= '0;
            r_rr_ptr    <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_err       <= 1'b0;
        end else begin
            if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (w_op == PQ_OP_ENQ) begin
                r_count  <= r_count + L'(1);
                r_rr_ptr <= w_ptr_nxt;
            end
            if (r_state == ST_DEQ_WAIT) begin
                if (pq_deq_valid) begin
                    r_out_data  <= pq_deq_value;
                    r_out_valid <= 1'b1;
                    r_count     <= r_count - L'(1);
                end else begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    assign count     = r_count;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign err       = r_err;

`ifdef PQ_SCHED_STATS_EN
    logic [STAT_W-1:0] r_stat_enq;
    logic [STAT_W-1:0] r_stat_deq;
    logic [STAT_W-1:0] r_stat_full_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_enq        <= '0;
            r_stat_deq        <= '0;
            r_stat_full_stall <= '0;
        end else begin
            if (w_op == PQ_OP_ENQ) begin
                r_stat_enq <= r_stat_enq + STAT_W'(1);
            end
            if ((r_state == ST_DEQ_WAIT) && pq_deq_valid) begin
                r_stat_deq <= r_stat_deq + STAT_W'(1);
            end
            if ((r_state == ST_IDLE) && (|in_valid) && w_full) begin
                r_stat_full_stall <= r_stat_full_stall + STAT_W'(1);
            end
        end
    end

    assign stat_enq        = r_stat_enq;
    assign stat_deq        = r_stat_deq;
    assign stat_full_stall = r_stat_full_stall;
`endif

endmodule

// File: tb/tb_pq_sched.sv
// Directed and randomized bench for pq_sched with a behavioural max-priority queue behind it.
module tb_pq_sched;

    localparam int unsigned NREQ = 4;
    localparam int unsigned W    = 32;
    localparam int unsigned L    = 3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   in_valid;
    logic [NREQ*W-1:0] in_data;
    logic [NREQ-1:0]   in_ready;
    logic              out_valid;
    logic [W-1:0]      out_data;
    logic              out_ready;
    logic              pq_enq_valid;
    logic [W-1:0]      pq_enq_value;
    logic              pq_enq_ready;
    logic              pq_deq_req;
    logic [W-1:0]      pq_deq_value;
    logic              pq_deq_valid;
    logic [L-1:0]      count;
    logic              err;
`ifdef PQ_SCHED_STATS_EN
    logic [31:0]       stat_enq;
    logic [31:0]       stat_deq;
    logic [31:0]       stat_full_stall;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // pq model controls
    logic              enq_rdy;
    logic              force_inv;
    logic [W-1:0]      m_q[$];
    logic              m_deq_valid;
    logic [W-1:0]      m_deq_value;
    int                mi;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pq_sched #(.NREQ(NREQ), .W(W), .L(L)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_ready    (out_ready),
        .pq_enq_valid (pq_enq_valid),
        .pq_enq_value (pq_enq_value),
        .pq_enq_ready (pq_enq_ready),
        .pq_deq_req   (pq_deq_req),
        .pq_deq_value (pq_deq_value),
        .pq_deq_valid (pq_deq_valid),
        .count        (count),
        .err          (err)
`ifdef PQ_SCHED_STATS_EN
        ,
        .stat_enq        (stat_enq),
        .stat_deq        (stat_deq),
        .stat_full_stall (stat_full_stall)
`endif
    );

    assign pq_enq_ready = enq_rdy;
    assign pq_deq_valid = m_deq_valid;
    assign pq_deq_value = m_deq_value;

    // Behavioural pq: returns the maximum one cycle after a dequeue request.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q.delete();
            m_deq_valid <= 1'b0;
            m_deq_value <= '0;
        end else begin
            m_deq_valid <= 1'b0;
            if (pq_deq_req && !force_inv && (m_q.size() > 0)) begin
                mi = 0;
                for (int i = 1; i < m_q.size(); i++) if (m_q[i] > m_q[mi]) mi = i;
                m_deq_value <= m_q[mi];
                m_deq_valid <= 1'b1;
                m_q.delete(mi);
            end
            if (pq_enq_valid && enq_rdy) m_q.push_back(pq_enq_value);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached (got timeout, required $finish)");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        rst_n     = 1'b0;
        in_valid  = '0;
        in_data   = '0;
        out_ready = 1'b0;
        force_inv = 1'b0;
        enq_rdy   = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic send(input int r, input logic [W-1:0] v);
        bit done = 1'b0;
        in_data[r*W +: W] = v;
        in_valid[r]       = 1'b1;
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge clk);
            if (in_ready[r]) done = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid[r] = 1'b0;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL send r%0d val %0d: in_ready got 0 required 1 within 40 cycles", r, v);
        end
    endtask

    task automatic wait_out_valid(input int budget);
        bit seen = 1'b0;
        for (int k = 0; k < budget && !seen; k++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL wait_out_valid: out_valid got 0 required 1 within %0d cycles", budget);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 4'hF;
        in_data   = {32'd4, 32'd3, 32'd2, 32'd1};
        out_ready = 1'b0;
        force_inv = 1'b0;
        enq_rdy   = 1'b1;
        repeat (3) @(negedge clk);
        checks += 6;
        if (in_ready !== 4'h0) begin errors++; $display("FAIL reset in_ready got %h required 0", in_ready); end
        if (pq_enq_valid !== 1'b0) begin errors++; $display("FAIL reset pq_enq_valid got %b required 0", pq_enq_valid); end
        if (pq_deq_req !== 1'b0) begin errors++; $display("FAIL reset pq_deq_req got %b required 0", pq_deq_req); end
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid got %b required 0", out_valid); end
        if (count !== 3'd0) begin errors++; $display("FAIL reset count got %0d required 0", count); end
        if (err !== 1'b0) begin errors++; $display("FAIL reset err got %b required 0", err); end
        in_valid = '0;
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_round_robin();
        int g_idx[8];
        int g_cyc[8];
        int ng = 0;
        int deq_cyc = -1;
        logic [NREQ-1:0] hs;
        do_reset();
        in_data  = {32'd40, 32'd30, 32'd20, 32'd10};
        in_valid = 4'hF;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            hs = in_valid & in_ready;
            for (int i = 0; i < NREQ; i++) begin
                if (hs[i] && ng < 8) begin g_idx[ng] = i; g_cyc[ng] = cyc; ng++; end
            end
            if (pq_deq_req && deq_cyc < 0) deq_cyc = cyc;
            @(posedge clk);
            #1 in_valid = in_valid & ~hs;
        end
        checks++;
        if (ng !== 4) begin errors++; $display("FAIL rr grant count got %0d required 4", ng); end
        for (int i = 0; i < 4 && i < ng; i++) begin
            checks++;
            if (g_idx[i] !== i) begin errors++; $display("FAIL rr grant[%0d] got %0d required %0d", i, g_idx[i], i); end
        end
        if (ng == 4) begin
            checks += 4;
            if (deq_cyc - g_cyc[0] !== 2) begin errors++; $display("FAIL rr deq spacing got %0d required 2", deq_cyc - g_cyc[0]); end
            if (g_cyc[1] - g_cyc[0] !== 4) begin errors++; $display("FAIL rr gap01 got %0d required 4", g_cyc[1] - g_cyc[0]); end
            if (g_cyc[2] - g_cyc[1] !== 2) begin errors++; $display("FAIL rr gap12 got %0d required 2", g_cyc[2] - g_cyc[1]); end
            if (g_cyc[3] - g_cyc[2] !== 2) begin errors++; $display("FAIL rr gap23 got %0d required 2", g_cyc[3] - g_cyc[2]); end
        end
        @(negedge clk);
        checks += 3;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL rr out_valid got %b required 1", out_valid); end
        if (out_data !== 32'd10) begin errors++; $display("FAIL rr out_data got %0d required 10", out_data); end
        if (count !== 3'd3) begin errors++; $display("FAIL rr count got %0d required 3", count); end
    endtask

    task automatic test_ordering();
        logic [W-1:0] got[5];
        logic [W-1:0] exp_v[5];
        int n = 0;
        exp_v[0] = 32'd1; exp_v[1] = 32'd99; exp_v[2] = 32'd42; exp_v[3] = 32'd7; exp_v[4] = 32'd5;
        do_reset();
        send(0, 32'd1);
        wait_out_valid(10);
        send(0, 32'd5);
        send(0, 32'd99);
        send(0, 32'd42);
        send(0, 32'd7);
        @(negedge clk);
        checks++;
        if (count !== 3'd4) begin errors++; $display("FAIL order count before drain got %0d required 4", count); end
        @(posedge clk);
        #1 out_ready = 1'b1;
        for (int k = 0; k < 40 && n < 5; k++) begin
            @(negedge clk);
            if (out_valid && out_ready) begin got[n] = out_data; n++; end
        end
        checks++;
        if (n !== 5) begin errors++; $display("FAIL order drained got %0d required 5", n); end
        for (int i = 0; i < n; i++) begin
            checks++;
            if (got[i] !== exp_v[i]) begin errors++; $display("FAIL order out[%0d] got %0d required %0d", i, got[i], exp_v[i]); end
        end
        @(negedge clk);
        checks += 2;
        if (count !== 3'd0) begin errors++; $display("FAIL order final count got %0d required 0", count); end
        if (out_valid !== 1'b0) begin errors++; $display("FAIL order final out_valid got %b required 0", out_valid); end
        out_ready = 1'b0;
    endtask

    task automatic test_full();
        bit granted = 1'b0;
        do_reset();
        send(1, 32'd100);
        wait_out_valid(10);
        for (int v = 1; v <= 7; v++) send(v % NREQ, W'(v));
        @(negedge clk);
        checks++;
        if (count !== 3'd7) begin errors++; $display("FAIL full count got %0d required 7", count); end
        in_data[2*W +: W] = 32'd50;
        in_valid[2]       = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (in_ready !== 4'h0) granted = 1'b1;
        end
        checks++;
        if (granted) begin errors++; $display("FAIL full stall in_ready got 1 required 0 at CAP"); end
`ifdef PQ_SCHED_STATS_EN
        checks++;
        if (stat_full_stall == 32'd0) begin errors++; $display("FAIL full stat_full_stall got 0 required >0"); end
`endif
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        granted = 1'b0;
        for (int k = 0; k < 20 && !granted; k++) begin
            @(negedge clk);
            if (in_ready[2]) granted = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid[2] = 1'b0;
        checks++;
        if (!granted) begin errors++; $display("FAIL full 8th grant got 0 required 1 after drain"); end
        repeat (2) @(negedge clk);
        checks += 3;
        if (count !== 3'd7) begin errors++; $display("FAIL full refill count got %0d required 7", count); end
        if (out_valid !== 1'b1) begin errors++; $display("FAIL full out_valid got %b required 1", out_valid); end
        if (out_data !== 32'd7) begin errors++; $display("FAIL full out_data got %0d required 7", out_data); end
`ifdef PQ_SCHED_STATS_EN
        checks += 2;
        if (stat_enq !== 32'd9) begin errors++; $display("FAIL full stat_enq got %0d required 9", stat_enq); end
        if (stat_deq !== 32'd2) begin errors++; $display("FAIL full stat_deq got %0d required 2", stat_deq); end
`endif
    endtask

    task automatic test_random();
        int m_occ = 0;
        bit pend_deq = 1'b0;
        int last_op = -10;
        logic [NREQ-1:0] hs;
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            checks += 4;
            if (pq_enq_valid && pq_deq_req) begin errors++; $display("FAIL rand exclusive cyc %0d: both ops high, required at most one", cyc); end
            if ((pq_enq_valid && pq_enq_ready) || pq_deq_req) begin
                if (cyc - last_op < 2) begin errors++; $display("FAIL rand spacing cyc %0d got %0d required >=2", cyc, cyc - last_op); end
                last_op = cyc;
            end
            if (count !== L'(m_occ)) begin errors++; $display("FAIL rand count cyc %0d got %0d required %0d", cyc, count, m_occ); end
            if (!$onehot0(in_ready)) begin errors++; $display("FAIL rand onehot cyc %0d in_ready got %h required onehot0", cyc, in_ready); end
            hs = in_valid & in_ready;
            if (hs != '0) m_occ++;
            if (pend_deq && pq_deq_valid) m_occ--;
            pend_deq = pq_deq_req;
            @(posedge clk);
            #1;
            in_valid = in_valid & ~hs;
            for (int r = 0; r < NREQ; r++) begin
                if (!in_valid[r] && $urandom_range(0, 2) == 0) begin
                    in_valid[r]       = 1'b1;
                    in_data[r*W +: W] = $urandom;
                end
            end
            out_ready = 1'($urandom_range(0, 1));
            enq_rdy   = ($urandom_range(0, 7) != 0);
        end
        in_valid  = '0;
        out_ready = 1'b1;
        enq_rdy   = 1'b1;
        repeat (40) @(negedge clk);
        checks += 2;
        if (count !== 3'd0) begin errors++; $display("FAIL rand drain count got %0d required 0", count); end
        if (err !== 1'b0) begin errors++; $display("FAIL rand err got %b required 0", err); end
        out_ready = 1'b0;
    endtask

    task automatic test_error();
        do_reset();
        force_inv = 1'b1;
        send(0, 32'd33);
        repeat (12) @(negedge clk);
        checks += 3;
        if (err !== 1'b1) begin errors++; $display("FAIL error err got %b required 1", err); end
        if (count !== 3'd1) begin errors++; $display("FAIL error count got %0d required 1", count); end
        if (out_valid !== 1'b0) begin errors++; $display("FAIL error out_valid got %b required 0", out_valid); end
        force_inv = 1'b0;
        wait_out_valid(10);
        @(negedge clk);
        checks += 3;
        if (out_data !== 32'd33) begin errors++; $display("FAIL error recovered out_data got %0d required 33", out_data); end
        if (err !== 1'b1) begin errors++; $display("FAIL error sticky err got %b required 1", err); end
        if (count !== 3'd0) begin errors++; $display("FAIL error recovered count got %0d required 0", count); end
        rst_n = 1'b0;
        #1;
        checks += 4;
        if (err !== 1'b0) begin errors++; $display("FAIL midreset err got %b required 0", err); end
        if (count !== 3'd0) begin errors++; $display("FAIL midreset count got %0d required 0", count); end
        if (out_valid !== 1'b0) begin errors++; $display("FAIL midreset out_valid got %b required 0", out_valid); end
        if (out_data !== 32'd0) begin errors++; $display("FAIL midreset out_data got %0d required 0", out_data); end
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_ordering();
        test_full();
        test_error();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
